// File: rtl/xnor_i8_arbiter_pkg.sv
// Shared definitions for the xnor_i8_arbiter slice.
//   - Default geometry: requester count, operand width, pipeline depth.
//   - tag_bits(): width of a requester index (at least one bit).
//   - next_idx(): round-robin successor of an index, modulo the requester count.
// The pipeline-stage struct {valid, tag, y} is declared inside the top, because
// its field widths follow the top's NUM_REQ/WIDTH parameters.
package xnor_i8_arbiter_pkg;

   localparam int unsigned DEF_NUM_REQ = 4;
   localparam int unsigned DEF_WIDTH   = 8;
   localparam int unsigned DEF_LAT     = 2;

   function automatic int unsigned tag_bits(input int unsigned n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

   function automatic int unsigned next_idx(input int unsigned g, input int unsigned n);
      return (g + 1 >= n) ? 0 : g + 1;
   endfunction

endpackage

// File: rtl/xnor_i8_arbiter_rr_pick.sv
// xnor_rr_pick: combinational round-robin priority picker.
//   elig   in  N   requesters that may be granted this cycle
//   rr_ptr in  IW  index searched first; the search wraps modulo N
//   grant  out N   one-hot grant, all zero when nothing is eligible
//   idx    out IW  index of the granted requester (0 when no grant)
module xnor_rr_pick
   import xnor_i8_arbiter_pkg::*;
#(
   parameter int unsigned N  = DEF_NUM_REQ,
   parameter int unsigned IW = tag_bits(DEF_NUM_REQ)
) (
   input  logic [N-1:0]  elig,
   input  logic [IW-1:0] rr_ptr,
   output logic [N-1:0]  grant,
   output logic [IW-1:0] idx
);

   logic found;
   int   cand;

   // NOTE: every variable written here gets a default first, so no path leaves
   // one unassigned and no latch is inferred.
   always_comb begin
      grant = '0;
      idx   = '0;
      found = 1'b0;
      cand  = 0;
      for (int k = 0; k < int'(N); k++) begin
         cand = int'(rr_ptr) + k;
         if (cand >= int'(N)) cand = cand - int'(N);
         if (!found && elig[cand]) begin
            found       = 1'b1;
            grant[cand] = 1'b1;
            idx         = IW'(cand);
         end
      end
   end

endmodule

// File: rtl/xnor_i8_arbiter.sv
// xnor_i8_arbiter: round-robin sharing of one pipelined WIDTH-bit XNOR unit
// (y = ~(a ^ b)) between NUM_REQ requesters, each with a request and a
// response valid/ready port. One issue per cycle, LAT registered stages,
// results written into the owning requester's response slot.
//   clock      in  1              rising-edge clock
//   reset      in  1              asynchronous reset, active low
//   req_valid  in  NUM_REQ        request valid per requester
//   req_ready  out NUM_REQ        one-hot grant (0 during reset)
//   req_a      in  NUM_REQ*WIDTH  operand a, requester i at [i*WIDTH +: WIDTH]
//   req_b      in  NUM_REQ*WIDTH  operand b, same packing
//   rsp_valid  out NUM_REQ        result waiting in requester i's slot
//   rsp_ready  in  NUM_REQ        requester i consumes its slot
//   rsp_y      out NUM_REQ*WIDTH  slot contents, stable while rsp_valid[i]
module xnor_i8_arbiter
   import xnor_i8_arbiter_pkg::*;
#(
   parameter int unsigned NUM_REQ = DEF_NUM_REQ,
   parameter int unsigned WIDTH   = DEF_WIDTH,
   parameter int unsigned LAT     = DEF_LAT
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic [NUM_REQ-1:0]         req_valid,
   output logic [NUM_REQ-1:0]         req_ready,
   input  logic [NUM_REQ*WIDTH-1:0]   req_a,
   input  logic [NUM_REQ*WIDTH-1:0]   req_b,
   output logic [NUM_REQ-1:0]         rsp_valid,
   input  logic [NUM_REQ-1:0]         rsp_ready,
   output logic [NUM_REQ*WIDTH-1:0]   rsp_y
);

   localparam int unsigned TAG_W = tag_bits(NUM_REQ);

   typedef struct packed {
      logic             valid;
      logic [TAG_W-1:0] tag;
      logic [WIDTH-1:0] y;
   } stage_t;

   logic [NUM_REQ-1:0]            pending;
   logic [NUM_REQ-1:0]            slot_valid;
   logic [NUM_REQ-1:0][WIDTH-1:0] slot_y;
   logic [NUM_REQ-1:0][WIDTH-1:0] a_arr;
   logic [NUM_REQ-1:0][WIDTH-1:0] b_arr;
   logic [NUM_REQ-1:0]            elig;
   logic [NUM_REQ-1:0]            grant;
   logic [NUM_REQ-1:0]            handshake;
   logic [TAG_W-1:0]              rr_ptr;
   logic [TAG_W-1:0]              pick_idx;
   stage_t                        issue;
   stage_t                        wb;
   stage_t                        pipe [LAT];

   assign a_arr = req_a;
   assign b_arr = req_b;

   // A requester with an op in flight or a result parked in its slot is not
   // eligible, which bounds each requester to one outstanding op and removes
   // any need to stall the pipeline.
   assign elig = req_valid & ~pending;

   xnor_rr_pick #(
      .N  (NUM_REQ),
      .IW (TAG_W)
   ) u_pick (
      .elig   (elig),
      .rr_ptr (rr_ptr),
      .grant  (grant),
      .idx    (pick_idx)
   );

   // Grants are suppressed while reset is held, even if req_valid is high.
   assign req_ready = reset ? grant : '0;
   assign handshake = slot_valid & rsp_ready;

   // The XNOR is evaluated ahead of stage 1, so the stages only carry results.
   always_comb begin
      issue.valid = |req_ready;
      issue.tag   = pick_idx;
      issue.y     = ~(a_arr[pick_idx] ^ b_arr[pick_idx]);
   end

   assign wb = pipe[LAT-1];

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples values from before the edge, independent of statement order.
   // NOTE: the stage array is reset as a whole: a stale valid bit surviving
   // reset would write a discarded op into a slot afterwards.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int s = 0; s < int'(LAT); s++) pipe[s] <= '0;
      end else begin
         pipe[0] <= issue;
         for (int s = 1; s < int'(LAT); s++) pipe[s] <= pipe[s-1];
      end
   end

   // Slot bookkeeping. A grant and a handshake never hit the same index in one
   // cycle (a pending requester is not eligible), and a writeback never meets a
   // handshake on the same index (the slot holds one op), so the per-index
   // updates below never compete.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         pending    <= '0;
         slot_valid <= '0;
         slot_y     <= '0;
         rr_ptr     <= '0;
      end else begin
         for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (handshake[i]) begin
               slot_valid[i] <= 1'b0;
               pending[i]    <= 1'b0;
            end
            if (req_ready[i]) pending[i] <= 1'b1;
            if (wb.valid && wb.tag == TAG_W'(i)) begin
               slot_valid[i] <= 1'b1;
               slot_y[i]     <= wb.y;
            end
         end
         if (issue.valid) rr_ptr <= TAG_W'(next_idx(32'(pick_idx), NUM_REQ));
      end
   end

   assign rsp_valid = slot_valid;
   assign rsp_y     = slot_y;

endmodule

// File: doc/xnor_i8_arbiter.md
Name: xnor_i8_arbiter

Overview:
- Shares one pipelined 8-bit bitwise-XNOR unit (y = ~(a ^ b)) between NUM_REQ requesters.
- Each requester has a valid/ready request port and a valid/ready response port.
- Round-robin arbiter issues at most one operation per cycle into the unit and routes each result back to its requester's response slot.
- Sits between the requesting datapath blocks and the shared xnor_i8_i8_i8-style resource.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- WIDTH, 8, operand/result width in bits.
- LAT, 2, pipeline depth of the shared unit in registered stages (1..4).

Ports:
- clock  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester grant; at most one bit high.
- req_a  in  NUM_REQ*WIDTH  packed operand a; requester i uses bits [i*WIDTH +: WIDTH].
- req_b  in  NUM_REQ*WIDTH  packed operand b; same packing as req_a.
- rsp_valid  out  NUM_REQ  result available in requester i's slot.
- rsp_ready  in  NUM_REQ  requester i consumes its slot.
- rsp_y  out  NUM_REQ*WIDTH  packed results, held stable while rsp_valid[i] is high.

Behaviour:
- Reset (reset=0, async):
  - pending, rsp_valid, pipeline valid bits and rsp_y all go to 0.
  - rr_ptr goes to 0.
  - req_ready is 0 while reset is asserted.
  - In-flight operations are discarded.
- Eligibility:
  - elig[i] = req_valid[i] & ~pending[i].
  - pending[i] sets on grant and clears on the response handshake (rsp_valid[i] & rsp_ready[i]).
  - This allows at most one outstanding op per requester, so slots never overflow.
- Arbitration (combinational):
  - req_ready is one-hot: the first eligible index searching rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - req_ready may depend on req_valid; req_valid must not depend on req_ready.
  - No eligible requester gives req_ready = 0.
- Pointer update:
  - On a grant to index g, rr_ptr <= (g+1) mod NUM_REQ.
  - With no grant, rr_ptr holds.
- Pipeline:
  - The granted a, b and index g enter stage 1 with valid=1.
  - Stages shift every cycle with no stall; stalls are never needed because each slot is reserved by pending.
  - The result is ~(a ^ b), computed before or in stage 1, WIDTH bits, no arithmetic.
- Writeback:
  - When stage LAT is valid with tag g, on that edge rsp_valid[g] <= 1 and rsp_y[g] <= result.
  - Latency: acceptance at edge E0 makes rsp_valid[g] high after edge E0+LAT.
- Response handshake:
  - rsp_valid[i] & rsp_ready[i] at an edge clears rsp_valid[i] and pending[i].
  - Requester i becomes eligible again in the following cycle, not the same cycle.
- Simultaneous events:
  - Writeback for i and a handshake for i cannot coincide, because the slot holds one op.
  - Writebacks for different requesters cannot coincide (one issue per cycle).
- Starvation bound: a continuously eligible requester is granted within NUM_REQ cycles.
- Reset deasserted mid-operation: the first grant may occur in the first cycle after release.

Decomposition:
- Shared package: WIDTH default, tag width = $clog2(NUM_REQ), and a pipeline-stage struct {valid, tag, y}.
- One natural sub-module, xnor_rr_pick: combinational round-robin priority picker (elig, rr_ptr -> one-hot grant, index).
- Pipeline and slot registers stay in the top.

Test Plan:
- Single op: req 0, a=8'd3, b=8'd12, LAT=2 -> req_ready[0] same cycle; rsp_valid[0] two edges later with rsp_y[0]=8'hF0 (-16).
- All four requesters valid at once from reset, operands a=i, b=8'hFF -> grants in order 0,1,2,3 on consecutive cycles; each rsp_y[i] = i.
- Requester 1 holds rsp_ready=0 -> no second grant to 1 while rsp_valid[1]=1; others keep being granted round-robin.
- Fairness: reqs 0 and 2 always valid, responses consumed immediately -> grants alternate 0,2,0,2; rr_ptr wraps 3->0 correctly.
- Mid-operation reset: issue 3 ops, pull reset low for one cycle before writeback -> all rsp_valid=0, no stale result appears afterwards, rr_ptr=0.
- Back-to-back: req 3, rsp_ready tied 1 -> a new grant every LAT+2 cycles; a=8'hAA, b=8'h55 -> 8'h00; a=b=8'h5A -> 8'hFF.
